// File: rtl/wb_write_arbiter_pkg.sv
// mips_pkg: shared register-file widths, zero-register constant and write bundle.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if: WB-stage, mul/div result channel and register-file write port bundle.
interface wb_write_arbiter_if #(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int REG_AW     = mips_pkg::REG_AW,
  parameter int FIFO_DEPTH = 2
);
  logic                          wb_RegWrite;
  logic [REG_AW-1:0]             wb_write_reg;
  logic                          MemtoReg;
  logic [DATA_W-1:0]             mem_Read_data;
  logic [DATA_W-1:0]             mem_ALU_result;
  logic                          md_valid;
  logic                          md_ready;
  logic [REG_AW-1:0]             md_write_reg;
  logic [DATA_W-1:0]             md_result;
  logic                          rf_we;
  logic [REG_AW-1:0]             rf_waddr;
  logic [DATA_W-1:0]             rf_wdata;
  logic                          pipe_stall;
  logic [$clog2(FIFO_DEPTH):0]   md_pending;
  modport master (
    output wb_RegWrite, wb_write_reg, MemtoReg, mem_Read_data, mem_ALU_result,
    output md_valid, md_write_reg, md_result,
    input  md_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, md_pending
  );
  modport slave (
    input  wb_RegWrite, wb_write_reg, MemtoReg, mem_Read_data, mem_ALU_result,
    input  md_valid, md_write_reg, md_result,
    output md_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, md_pending
  );
endinterface

// File: rtl/wb_write_arbiter_md_fifo.sv
// wb_md_fifo: small synchronous FIFO buffering mul/div {addr, data} results.
module wb_md_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            din,
  output logic [W-1:0]            dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout  = mem[rp];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(push);
      rp    <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the register-file write port between WB and mul/div results.
module wb_write_arbiter #(
  parameter int DATA_W       = mips_pkg::DATA_W,
  parameter int REG_AW       = mips_pkg::REG_AW,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               rst_n,
  wb_write_arbiter_if.slave bus
);
  localparam int AGW = $clog2(STARVE_LIMIT + 1);
  localparam logic [REG_AW-1:0] ZERO = REG_AW'(mips_pkg::REG_ZERO);
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;
  req_t           head, pipe_req, md_req, win;
  logic           full, empty, push, pop, bypass, we_n;
  logic           pipe_ok, md_ok, xfer, stall;
  logic [AGW-1:0] age;
  assign stall          = age == AGW'(STARVE_LIMIT);
  assign bus.pipe_stall = stall;
  assign bus.md_ready   = rst_n && !full;
  assign xfer           = bus.md_valid && bus.md_ready;
  assign pipe_ok        = bus.wb_RegWrite && bus.wb_write_reg != ZERO;
  assign md_ok          = xfer && bus.md_write_reg != ZERO;
  assign pipe_req       = '{addr: bus.wb_write_reg,
                            data: bus.MemtoReg ? bus.mem_Read_data : bus.mem_ALU_result};
  assign md_req         = '{addr: bus.md_write_reg, data: bus.md_result};
  // a forced drain outranks the pipeline; register-0 writes never claim the port
  always_comb begin
    pop    = !empty && (stall || !pipe_ok);
    bypass = empty && !pipe_ok && md_ok;
    push   = md_ok && !bypass;
    we_n   = pop || bypass || (pipe_ok && !stall);
    win    = (stall || !pipe_ok) ? (empty ? md_req : head) : pipe_req;
  end
  wb_md_fifo #(.W(REG_AW + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (md_req),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (bus.md_pending)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) age <= '0;
    else        age <= (empty || pop) ? '0 : stall ? age : age + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else begin
      bus.rf_we <= we_n;
      if (we_n) {bus.rf_waddr, bus.rf_wdata} <= win;
    end
endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Shares the single register-file write port between the pipeline writeback stage and the multi-cycle multiply/divide unit's result channel. It owns the writeback mux, which selects `mem_Read_data` or `mem_ALU_result` under `MemtoReg`. Pipeline writes always win; mul/div results are buffered in a small FIFO and drained on free port cycles. A starvation guard forces a one-cycle pipeline stall so buffered results eventually retire. It sits between the WB stage and the register file.

## Interface
- `DATA_W`, 32, register data width
- `REG_AW`, 5, register address width
- `FIFO_DEPTH`, 2, mul/div result buffer entries (power of two, ≥2)
- `STARVE_LIMIT`, 8, cycles a buffered head may wait before a forced drain (≥1)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wb_RegWrite`  in  1  pipeline WB stage requests a write
- `wb_write_reg`  in  REG_AW  pipeline destination register
- `MemtoReg`  in  1  1 selects `mem_Read_data`, 0 selects `mem_ALU_result`
- `mem_Read_data`  in  DATA_W  load data
- `mem_ALU_result`  in  DATA_W  ALU result
- `md_valid`  in  1  mul/div result valid
- `md_ready`  out  1  arbiter can accept a mul/div result
- `md_write_reg`  in  REG_AW  mul/div destination register
- `md_result`  in  DATA_W  mul/div result
- `rf_we`  out  1  register-file write enable (registered)
- `rf_waddr`  out  REG_AW  write address (registered)
- `rf_wdata`  out  DATA_W  write data (registered)
- `pipe_stall`  out  1  pipeline must hold the WB stage this cycle
- `md_pending`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- Handshake: an md transfer occurs when `md_valid && md_ready`. `md_ready = !full`, and is 0 while `rst_n` is low. The producer holds its data until the transfer completes.
- Each cycle, one winner is chosen in priority order:
  1. Forced drain (`pipe_stall=1`): the FIFO head is written. `wb_RegWrite` is ignored, and the pipeline re-presents the same WB request next cycle.
  2. Pipeline write: `wb_RegWrite=1` and `wb_write_reg≠0`.
  3. FIFO head, if the FIFO is non-empty.
  4. Bypass: the FIFO is empty and an md transfer occurs. The result is written directly and never enters the FIFO.
  5. Otherwise idle: `rf_we=0`.
- Writes to register 0 from either source are discarded. A discarded write does not occupy the port; an md write to register 0 is accepted and dropped.
- An md transfer that is not bypassed is pushed to the FIFO. Push and pop in the same cycle leave the count unchanged.
- FIFO drain order is strict FIFO. Bypass occurs only when the FIFO is empty, so mul/div results retire in order.
- WAW ordering between in-flight mul/div results and pipeline writes is the issue scoreboard's responsibility, not this block's.
- Age counter:
  - Cleared when the FIFO is empty or the head pops.
  - Otherwise increments, saturating at STARVE_LIMIT.
  - `pipe_stall = (age == STARVE_LIMIT)`, decoded from a register only, with no combinational path from inputs.
- Reset behaviour:
  - Outputs `rf_we`, `rf_waddr`, `rf_wdata`, `pipe_stall` and `md_pending` reset to 0. Age and FIFO pointers reset to 0.
  - Reset mid-operation discards buffered results. The mul/div unit shares `rst_n`.

## Timing
- Write latency is 1 cycle. The winner selected in cycle N appears on `rf_*` after edge N+1 and stays for exactly one cycle unless a new winner follows.
- `rf_wdata` reflects the `MemtoReg` mux value sampled at the edge.
- `md_ready` and `md_pending` update at the edge after a push or pop.
- `pipe_stall` is high for exactly one cycle per forced drain. Age returns to 0 afterwards, or restarts counting if further entries remain.
- Full FIFO with continuous pipeline writes: `md_ready=0` until a drain.

## Structure
- Shared package `mips_pkg`: `DATA_W`, `REG_AW`, `REG_ZERO` constant, and a `wb_req_t`-style {addr, data} bundle definition.
- One sub-module, `wb_md_fifo`: a synchronous FIFO of {REG_AW+DATA_W} entries with push/pop/full/empty/count.
- The arbiter top holds the mux, the priority select, the age counter and the output registers.

## Test plan
- Pipeline only:
  - `wb_RegWrite=1`, reg 3, `MemtoReg=0`, ALU=42, Read=100 → next cycle `rf_we=1`, `rf_waddr=3`, `rf_wdata=42`.
  - Then `MemtoReg=1`, Read=200 → `rf_wdata=200`.
- Bypass: pipeline idle, md reg 9 = 0x1234 → next cycle write reg 9 = 0x1234, `md_pending` stays 0.
- Conflict: same cycle, pipeline reg 2 = 84 and md reg 4 = 7 → reg 2 = 84 written, `md_pending=1`, `md_ready=1`. Next idle cycle → reg 4 = 7, `md_pending=0`.
- Full/backpressure: continuous pipeline writes plus 3 md results → 2 accepted, `md_ready=0`, and the third is held. After pipeline idle, all drain in order.
- Starvation, with `STARVE_LIMIT=4`: one buffered entry under continuous pipeline writes → `pipe_stall` high for exactly one cycle, head written, and the held pipeline write retires the next cycle.
- Register 0 and reset:
  - Pipeline write to reg 0 while an entry is buffered → FIFO head written that cycle.
  - Assert `rst_n` low with 2 entries buffered → all outputs 0, `md_ready=0`, `md_pending=0`. After release, `md_ready=1`.
